// File: rtl/alu_op_sequencer_pkg.sv
// Shared constants for the ALU operation sequencer: ALU opcodes, FSM state encoding
// and the settle-counter width.
package alu_seq_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_RESP = 2'd2;

  localparam int CNT_W = 4;

endpackage

// File: rtl/alu_op_sequencer_stats.sv
// Response statistics for the ALU sequencer (built only when ALU_SEQ_STATS_EN is defined):
// completed handshakes and handshakes that carried out. Both counters wrap.
module alu_seq_stats (
  input  logic       clk,
  input  logic       rst,
  input  logic       hs,
  input  logic       co,
  output logic [7:0] stat_ops,
  output logic [7:0] stat_carries
);

  // Count response handshakes and those with carry set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_ops     <= 8'd0;
      stat_carries <= 8'd0;
    end else if (hs) begin
      stat_ops <= stat_ops + 8'd1;
      if (co) begin
        stat_carries <= stat_carries + 8'd1;
      end
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Command/response sequencer driving a combinational ALU with a programmable settle time.
// Optional statistics outputs are enabled with ALU_SEQ_STATS_EN.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             cmd_use_acc,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_s,
  input  logic [WIDTH-1:0] alu_c,
  input  logic             alu_co,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_c,
  output logic             rsp_co,
  output logic             rsp_zero,
  output logic [WIDTH-1:0] acc
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [7:0]       stat_ops,
  output logic [7:0]       stat_carries
`endif
);

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             accept_s;
  logic             hs_s;

  assign accept_s = cmd_valid && cmd_ready;
  assign hs_s     = rsp_valid && rsp_ready;

  // Control FSM with operand, result and accumulator registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      cmd_ready <= 1'b1;
      alu_a     <= {WIDTH{1'b0}};
      alu_b     <= {WIDTH{1'b0}};
      alu_s     <= 2'b00;
      rsp_valid <= 1'b0;
      rsp_c     <= {WIDTH{1'b0}};
      rsp_co    <= 1'b0;
      rsp_zero  <= 1'b0;
      acc       <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            alu_a     <= cmd_use_acc ? acc : cmd_a;
            alu_b     <= cmd_b;
            alu_s     <= cmd_op;
            cnt_r     <= CNT_W'(SETTLE_CYCLES - 1);
            cmd_ready <= 1'b0;
            state_r   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // Counter reaching zero marks the edge where the ALU output has settled
          if (cnt_r == {CNT_W{1'b0}}) begin
            rsp_c     <= alu_c;
            rsp_co    <= alu_co;
            rsp_zero  <= (alu_c == {WIDTH{1'b0}});
            acc       <= alu_c;
            rsp_valid <= 1'b1;
            state_r   <= ST_RESP;
          end else begin
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_RESP: begin
          if (hs_s) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state_r   <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef ALU_SEQ_STATS_EN
  alu_seq_stats u_stats (
    .clk          (clk),
    .rst          (rst),
    .hs           (hs_s),
    .co           (rsp_co),
    .stat_ops     (stat_ops),
    .stat_carries (stat_carries)
  );
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: one instance with SETTLE_CYCLES=1, one with 3,
// each wired to a 4-bit ALU model. Stats checks appear when ALU_SEQ_STATS_EN is defined.
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [1:0] cmd_op;
  logic [3:0] cmd_a, cmd_b;
  logic       cmd_use_acc;

  logic       cmd_valid1, cmd_ready1, rsp_valid1, rsp_ready1, rsp_co1, rsp_zero1, alu_co1;
  logic [3:0] alu_a1, alu_b1, alu_c1, rsp_c1, acc1;
  logic [1:0] alu_s1;
  logic       cmd_valid3, cmd_ready3, rsp_valid3, rsp_ready3, rsp_co3, rsp_zero3, alu_co3;
  logic [3:0] alu_a3, alu_b3, alu_c3, rsp_c3, acc3;
  logic [1:0] alu_s3;
`ifdef ALU_SEQ_STATS_EN
  logic [7:0] so1, sc1, so3, sc3;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  // 4-bit ALU: subtraction as a + ~b + 1, so carry out means "no borrow"
  function automatic logic [4:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [1:0] s);
    case (s)
      2'b00:   alu_f = {1'b0, a} + {1'b0, b};
      2'b01:   alu_f = {1'b0, a} + {1'b0, ~b} + 5'd1;
      2'b10:   alu_f = {1'b0, a & b};
      default: alu_f = {1'b0, a | b};
    endcase
  endfunction

  always_comb {alu_co1, alu_c1} = alu_f(alu_a1, alu_b1, alu_s1);
  always_comb {alu_co3, alu_c3} = alu_f(alu_a3, alu_b3, alu_s3);

  alu_op_sequencer #(.WIDTH(4), .SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
    .alu_a(alu_a1), .alu_b(alu_b1), .alu_s(alu_s1), .alu_c(alu_c1), .alu_co(alu_co1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_c(rsp_c1), .rsp_co(rsp_co1),
    .rsp_zero(rsp_zero1), .acc(acc1)
`ifdef ALU_SEQ_STATS_EN
    , .stat_ops(so1), .stat_carries(sc1)
`endif
  );

  alu_op_sequencer #(.WIDTH(4), .SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
    .alu_a(alu_a3), .alu_b(alu_b3), .alu_s(alu_s3), .alu_c(alu_c3), .alu_co(alu_co3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_c(rsp_c3), .rsp_co(rsp_co3),
    .rsp_zero(rsp_zero3), .acc(acc3)
`ifdef ALU_SEQ_STATS_EN
    , .stat_ops(so3), .stat_carries(sc3)
`endif
  );

  typedef struct {
    logic [1:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic       ua;
    logic [3:0] ea;
    logic [3:0] c;
    logic       co;
    logic       z;
    logic [3:0] acc;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  // One full operation on the SETTLE_CYCLES=1 instance
  task automatic run1(input vec_t v);
    int lat;
    @(negedge clk);
    cmd_op = v.op; cmd_a = v.a; cmd_b = v.b; cmd_use_acc = v.ua; cmd_valid1 = 1'b1;
    chk("s1_ready_idle", cmd_ready1, 1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid1 = 1'b0;
    chk("s1_alu_a", alu_a1, v.ea);
    chk("s1_alu_b", alu_b1, v.b);
    chk("s1_alu_s", alu_s1, v.op);
    chk("s1_ready_busy", cmd_ready1, 0);
    lat = 0;
    while (!rsp_valid1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("s1_latency", lat, 1);
    chk("s1_rsp_c", rsp_c1, v.c);
    chk("s1_rsp_co", rsp_co1, v.co);
    chk("s1_rsp_zero", rsp_zero1, v.z);
    chk("s1_acc", acc1, v.acc);
    rsp_ready1 = 1'b1;
    @(negedge clk);
    rsp_ready1 = 1'b0;
    chk("s1_valid_drop", rsp_valid1, 0);
    chk("s1_ready_back", cmd_ready1, 1);
    chk("s1_rsp_c_hold", rsp_c1, v.c);
  endtask

  // One full operation on the SETTLE_CYCLES=3 instance
  task automatic run3(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] ec, input logic eco);
    int lat;
    @(negedge clk);
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = 1'b0; cmd_valid3 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid3 = 1'b0;
    lat = 0;
    while (!rsp_valid3 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("s3_latency", lat, 3);
    chk("s3_rsp_c", rsp_c3, ec);
    chk("s3_rsp_co", rsp_co3, eco);
    rsp_ready3 = 1'b1;
    @(negedge clk);
    rsp_ready3 = 1'b0;
    chk("s3_valid_drop", rsp_valid3, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int lat;
    vecs[0] = '{OP_ADD, 4'h7, 4'h9, 1'b0, 4'h7, 4'h0, 1'b1, 1'b1, 4'h0};
    vecs[1] = '{OP_AND, 4'hC, 4'hA, 1'b0, 4'hC, 4'h8, 1'b0, 1'b0, 4'h8};
    vecs[2] = '{OP_ADD, 4'h3, 4'h4, 1'b0, 4'h3, 4'h7, 1'b0, 1'b0, 4'h7};
    vecs[3] = '{OP_ADD, 4'hF, 4'h5, 1'b1, 4'h7, 4'hC, 1'b0, 1'b0, 4'hC};
    vecs[4] = '{OP_OR,  4'h5, 4'hA, 1'b0, 4'h5, 4'hF, 1'b0, 1'b0, 4'hF};
    vecs[5] = '{OP_SUB, 4'h5, 4'h5, 1'b0, 4'h5, 4'h0, 1'b1, 1'b1, 4'h0};
    vecs[6] = '{OP_SUB, 4'h3, 4'h5, 1'b0, 4'h3, 4'hE, 1'b0, 1'b0, 4'hE};
    vecs[7] = '{OP_ADD, 4'h0, 4'h3, 1'b1, 4'hE, 4'h1, 1'b1, 1'b0, 4'h1};

    rst = 1'b1;
    cmd_valid1 = 1'b0; cmd_valid3 = 1'b0; rsp_ready1 = 1'b0; rsp_ready3 = 1'b0;
    cmd_op = 2'b00; cmd_a = 4'h0; cmd_b = 4'h0; cmd_use_acc = 1'b0;
    #2;
    chk("rst_ready", cmd_ready1, 1);
    chk("rst_valid", rsp_valid1, 0);
    chk("rst_acc", acc1, 0);
    chk("rst_rsp_c", rsp_c1, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run1(vecs[i]);

    // Asynchronous reset asserted between clock edges
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_alu_a", alu_a1, 0);
    chk("arst_alu_b", alu_b1, 0);
    chk("arst_rsp_c", rsp_c1, 0);
    chk("arst_rsp_co", rsp_co1, 0);
    chk("arst_acc", acc1, 0);
    chk("arst_valid", rsp_valid1, 0);
    chk("arst_ready", cmd_ready1, 1);
    @(negedge clk);
    rst = 1'b0;

    // Backpressure on SETTLE_CYCLES=3 with a second command held during the busy phase
    @(negedge clk);
    cmd_op = OP_ADD; cmd_a = 4'h2; cmd_b = 4'h3; cmd_use_acc = 1'b0; cmd_valid3 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_op = OP_OR; cmd_a = 4'hF; cmd_b = 4'h0;
    chk("bp_alu_a_first", alu_a3, 2);
    lat = 0;
    while (!rsp_valid3 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("bp_latency", lat, 3);
    chk("bp_rsp_c", rsp_c3, 5);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_valid_hold", rsp_valid3, 1);
      chk("bp_rsp_c_hold", rsp_c3, 5);
      chk("bp_ready_low", cmd_ready3, 0);
      chk("bp_alu_a_hold", alu_a3, 2);
    end
    rsp_ready3 = 1'b1;
    @(negedge clk);
    rsp_ready3 = 1'b0;
    chk("bp_valid_drop", rsp_valid3, 0);
    chk("bp_ready_back", cmd_ready3, 1);
    chk("bp_no_early_accept", alu_a3, 2);
    @(negedge clk);
    cmd_valid3 = 1'b0;
    chk("bp_second_alu_a", alu_a3, 15);
    chk("bp_second_alu_s", alu_s3, 3);
    chk("bp_second_busy", cmd_ready3, 0);
    lat = 0;
    while (!rsp_valid3 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("bp_second_latency", lat, 3);
    chk("bp_second_rsp_c", rsp_c3, 15);
    rsp_ready3 = 1'b1;
    @(negedge clk);
    rsp_ready3 = 1'b0;

    // Reset pulse while the command is still settling
    @(negedge clk);
    cmd_op = OP_ADD; cmd_a = 4'h9; cmd_b = 4'h9; cmd_valid3 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid3 = 1'b0;
    chk("wr_in_wait", cmd_ready3, 0);
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("wr_no_rsp", rsp_valid3, 0);
    end
    chk("wr_acc", acc3, 0);
    chk("wr_ready", cmd_ready3, 1);
`ifdef ALU_SEQ_STATS_EN
    chk("wr_stat_ops", so3, 0);
    chk("wr_stat_carries", sc3, 0);
`endif
    run3(OP_ADD, 4'h9, 4'h9, 4'h2, 1'b1);
`ifdef ALU_SEQ_STATS_EN
    chk("st_ops_1", so3, 1);
    chk("st_carries_1", sc3, 1);
`endif
    run3(OP_AND, 4'h1, 4'h1, 4'h1, 1'b0);
`ifdef ALU_SEQ_STATS_EN
    chk("st_ops_2", so3, 2);
    chk("st_carries_2", sc3, 1);
`endif
    chk("acc_after", acc3, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
